// File: rtl/score_frame_pkg.sv
// Shared definitions for the score frame link (transmitter and matching receiver).
package score_frame_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int FRAME_BYTES = 5;

  // Frame word field positions
  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 28;
  localparam int RSVD_MSB = 27;
  localparam int RSVD_LSB = 26;
  localparam int ID_MSB   = 25;
  localparam int ID_LSB   = 24;
  localparam int PTS_MSB  = 23;
  localparam int PTS_LSB  = 0;

  localparam logic [3:0] DEF_SYNC_NIBBLE = 4'hA;

  // Build the 32-bit frame word shared with the display side
  function automatic logic [31:0] pack_frame(input logic [3:0]  sync,
                                             input logic [1:0]  id,
                                             input logic [23:0] pts);
    return {sync, 2'b00, id, pts};
  endfunction

endpackage

// File: rtl/score_frame_tx_resend_timer.sv
// Free-running idle timer: saturates at CYCLES-1, pulses o_expire on the
// edge that brings it to CYCLES-1. CYCLES must be at least 2.
module resend_timer #(
  parameter logic [31:0] CYCLES = 32'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [31:0] LAST = CYCLES - 32'd1;
  localparam logic [31:0] HIT  = CYCLES - 32'd2;

  logic [31:0] r_cnt;

  // Count up to LAST and hold there; clear restarts the interval
  always_ff @(posedge clk) begin
    if (rst || i_clear) r_cnt <= '0;
    else if (r_cnt != LAST) r_cnt <= r_cnt + 32'd1;
  end

  // Single-cycle pulse: HIT is only passed once per count-up
  assign o_expire = (r_cnt == HIT);

endmodule

// File: rtl/score_frame_tx.sv
// Score frame transmitter: 4 frame bytes plus XOR checksum over a
// valid/ready byte interface, triggered by send, score change or resend timer.
module score_frame_tx
  import score_frame_pkg::*;
#(
  parameter logic [31:0] RESEND_CYCLES = 32'd1_000_000,
  parameter logic [3:0]  SYNC_NIBBLE   = DEF_SYNC_NIBBLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] points,
  input  logic [1:0]  board_ID,
  input  logic        send,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);
  localparam logic [2:0] CSUM_PREV = 3'(FRAME_BYTES - 2);

  state_t      r_state, w_next;
  logic [31:0] r_shift;
  logic [7:0]  r_tx_data, r_csum;
  logic        r_tx_valid, r_done, r_pending;
  logic [2:0]  r_idx;
  logic [23:0] r_last_points;

  logic        w_expire, w_trig, w_load, w_xfer, w_last, w_tmr_clear, w_busy;
  logic [31:0] w_frame;

  assign w_frame     = pack_frame(SYNC_NIBBLE, board_ID, points);
  assign w_xfer      = r_tx_valid & tx_ready;
  assign w_last      = w_xfer & (r_idx == LAST_BYTE);
  assign w_trig      = send | (points != r_last_points) | w_expire;
  assign w_load      = (r_state == IDLE) & (r_pending | w_trig);
  // Timer runs only across idle time: held clear through the frame and the done cycle
  assign w_tmr_clear = w_load | (r_state == SEND) | r_done;

  resend_timer #(.CYCLES(RESEND_CYCLES)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_tmr_clear),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_load) w_next = SEND;
      SEND:    if (w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy = (r_state == SEND);
  end

  // Frame shift register, checksum, pending flag and byte handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift       <= '0;
      r_tx_data     <= 8'h00;
      r_tx_valid    <= 1'b0;
      r_done        <= 1'b0;
      r_csum        <= 8'h00;
      r_idx         <= '0;
      r_last_points <= '0;
      r_pending     <= 1'b1;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift       <= w_frame;
        r_tx_data     <= w_frame[31:24];
        r_tx_valid    <= 1'b1;
        r_csum        <= 8'h00;
        r_idx         <= '0;
        r_last_points <= points;
        r_pending     <= 1'b0;
      end else if (r_state == SEND) begin
        if (w_trig) r_pending <= 1'b1;
        if (w_xfer) begin
          if (w_last) begin
            r_tx_valid <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_csum <= r_csum ^ r_tx_data;
            r_idx  <= r_idx + 3'd1;
            if (r_idx == CSUM_PREV) begin
              r_tx_data <= r_csum ^ r_tx_data;
            end else begin
              r_tx_data <= r_shift[23:16];
              r_shift   <= {r_shift[23:0], 8'h00};
            end
          end
        end
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = w_busy;
  assign done     = r_done;

endmodule

// File: tb/tb_score_frame_tx.sv
// Directed bench for score_frame_tx: reset, basic frame, stalls, board 0,
// mid-frame score change, mid-frame reset and periodic resend.
module tb_score_frame_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] points = 24'h0;
  logic [1:0]  board_ID = 2'b00;
  logic        send = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data, b_tx_data;
  logic        tx_valid, busy, done, b_tx_valid, b_busy, b_done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  score_frame_tx dut (
    .clk(clk), .rst(rst), .points(points), .board_ID(board_ID), .send(send),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done)
  );

  score_frame_tx #(.RESEND_CYCLES(32'd16)) dut_b (
    .clk(clk), .rst(rst), .points(points), .board_ID(board_ID), .send(send),
    .tx_ready(tx_ready), .tx_data(b_tx_data), .tx_valid(b_tx_valid), .busy(b_busy), .done(b_done)
  );

  // Collect one 5-byte frame starting at the current negedge. Returns after the
  // negedge that follows the checksum transfer (the done cycle).
  task automatic get_frame(input int mode, input int chg_at, input logic [23:0] chg_pts,
                           output logic [39:0] fr, output int cyc, output bit stable, output bit ok);
    logic [15:0] pat;
    logic [7:0]  prev;
    bit          stall;
    int          n, first;
    pat = 16'b0110_1100_1011_1001;
    prev = 8'h00; stall = 0; n = 0; first = -1;
    fr = '0; cyc = 0; stable = 1; ok = 0;
    for (int t = 0; t < 200 && n < 5; t++) begin
      tx_ready = (mode == 0) ? 1'b1 : pat[t % 16];
      if (tx_valid) begin
        if (first < 0) first = t;
        if (stall && tx_data !== prev) stable = 0;
        if (n == chg_at) points = chg_pts;
        if (tx_ready) begin
          fr = {fr[31:0], tx_data};
          n++;
          stall = 0;
        end else begin
          stall = 1;
          prev = tx_data;
        end
      end
      if (n == 5) begin cyc = t - first + 1; ok = 1; end
      @(negedge clk);
    end
    tx_ready = 1'b1;
  endtask

  task automatic test_reset();
    logic [39:0] fr; int cyc; bit st, ok;
    rst = 1'b1; points = 24'h001234; board_ID = 2'b10;
    repeat (2) @(negedge clk);
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid: got %b want 0", tx_valid); end
    nvec++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL rst_data: got %h want 00", tx_data); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %b want 0", done); end
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (tx_valid !== 1'b1) begin nerr++; $display("FAIL first_valid: got %b want 1", tx_valid); end
    nvec++; if (tx_data !== 8'hA2) begin nerr++; $display("FAIL first_hdr: got %h want A2", tx_data); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL first_busy: got %b want 1", busy); end
    get_frame(0, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (fr !== 40'hA2_001234_84) begin nerr++; $display("FAIL first_frame: got %h want A200123484", fr); end
  endtask

  task automatic test_basic();
    logic [39:0] fr; int cyc; bit st, ok;
    repeat (3) @(negedge clk);
    nvec++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL idle_quiet: got valid=%b busy=%b want 0 0", tx_valid, busy); end
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    nvec++; if (tx_valid !== 1'b1 || tx_data !== 8'hA2) begin nerr++; $display("FAIL send_latency: got valid=%b data=%h want 1 A2", tx_valid, tx_data); end
    get_frame(0, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL basic_timeout: got %b want 1", ok); end
    nvec++; if (fr !== 40'hA2_001234_84) begin nerr++; $display("FAIL basic_frame: got %h want A200123484", fr); end
    nvec++; if (cyc !== 5) begin nerr++; $display("FAIL basic_cycles: got %0d want 5", cyc); end
    nvec++; if (done !== 1'b1 || tx_valid !== 1'b0) begin nerr++; $display("FAIL basic_done: got done=%b valid=%b want 1 0", done, tx_valid); end
    @(negedge clk);
    nvec++; if (done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_stall();
    logic [39:0] fr; int cyc; bit st, ok;
    points = 24'h987654; board_ID = 2'b01;
    get_frame(1, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (ok !== 1'b1) begin nerr++; $display("FAIL stall_timeout: got %b want 1", ok); end
    nvec++; if (fr !== 40'hA1_987654_1B) begin nerr++; $display("FAIL stall_frame: got %h want A19876541B", fr); end
    nvec++; if (st !== 1'b1) begin nerr++; $display("FAIL stall_hold: got %b want 1", st); end
    nvec++; if ((cyc > 5) !== 1'b1) begin nerr++; $display("FAIL stall_seen: got %0d cycles want >5", cyc); end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL stall_done: got %b want 1", done); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_bid0();
    logic [39:0] fr; int cyc; bit st, ok;
    points = 24'h555555; board_ID = 2'b00;
    get_frame(0, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (fr !== 40'hA0_555555_F5) begin nerr++; $display("FAIL bid0_frame: got %h want A0555555F5", fr); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_midframe_change();
    logic [39:0] fr; int cyc; bit st, ok;
    points = 24'h000100; board_ID = 2'b10;
    get_frame(0, 2, 24'h000200, fr, cyc, st, ok);
    nvec++; if (fr !== 40'hA2_000100_A3) begin nerr++; $display("FAIL chg_frame1: got %h want A2000100A3", fr); end
    nvec++; if (tx_valid !== 1'b0 || done !== 1'b1) begin nerr++; $display("FAIL chg_gap: got valid=%b done=%b want 0 1", tx_valid, done); end
    @(negedge clk);
    nvec++; if (tx_valid !== 1'b1 || tx_data !== 8'hA2) begin nerr++; $display("FAIL chg_restart: got valid=%b data=%h want 1 A2", tx_valid, tx_data); end
    get_frame(0, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (fr !== 40'hA2_000200_A0) begin nerr++; $display("FAIL chg_frame2: got %h want A2000200A0", fr); end
    repeat (3) @(negedge clk);
    nvec++; if (tx_valid !== 1'b0) begin nerr++; $display("FAIL chg_no_third: got %b want 0", tx_valid); end
  endtask

  task automatic test_rst_midframe();
    logic [39:0] fr; int cyc; bit st, ok;
    points = 24'h123456; board_ID = 2'b11;
    get_frame(0, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (fr !== 40'hA3_123456_D3) begin nerr++; $display("FAIL ab_pre_frame: got %h want A3123456D3", fr); end
    repeat (2) @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (3) @(negedge clk);
    nvec++; if (tx_data !== 8'h56) begin nerr++; $display("FAIL ab_byte3: got %h want 56", tx_data); end
    rst = 1'b1;
    @(negedge clk);
    nvec++; if (tx_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL ab_abort: got valid=%b done=%b busy=%b want 0 0 0", tx_valid, done, busy); end
    nvec++; if (tx_data !== 8'h00) begin nerr++; $display("FAIL ab_data: got %h want 00", tx_data); end
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (tx_valid !== 1'b1 || tx_data !== 8'hA3) begin nerr++; $display("FAIL ab_restart: got valid=%b data=%h want 1 A3", tx_valid, tx_data); end
    get_frame(0, -1, 24'h0, fr, cyc, st, ok);
    nvec++; if (fr !== 40'hA3_123456_D3) begin nerr++; $display("FAIL ab_post_frame: got %h want A3123456D3", fr); end
  endtask

  task automatic test_resend();
    int rise[8];
    logic [7:0] hdr;
    int nr, sched;
    bit pv;
    for (int i = 0; i < 8; i++) rise[i] = 0;
    nr = 0; sched = -1; pv = 0; hdr = 8'h00;
    rst = 1'b1; tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int t = 0; t < 140; t++) begin
      if (b_tx_valid && !pv) begin
        if (nr < 8) rise[nr] = t;
        if (nr == 0) hdr = b_tx_data;
        nr++;
      end
      pv = b_tx_valid;
      if (nr == 3 && sched < 0) sched = rise[2] + 20;
      send = (t == sched);
      @(negedge clk);
    end
    send = 1'b0;
    nvec++; if ((nr >= 5) !== 1'b1) begin nerr++; $display("FAIL resend_count: got %0d frames want >=5", nr); end
    nvec++; if (hdr !== 8'hA3) begin nerr++; $display("FAIL resend_hdr: got %h want A3", hdr); end
    nvec++; if (rise[1] - rise[0] !== 21) begin nerr++; $display("FAIL resend_period1: got %0d want 21", rise[1] - rise[0]); end
    nvec++; if (rise[2] - rise[1] !== 21) begin nerr++; $display("FAIL resend_period2: got %0d want 21", rise[2] - rise[1]); end
    nvec++; if (rise[3] - rise[2] !== 21) begin nerr++; $display("FAIL resend_coincident: got %0d want 21", rise[3] - rise[2]); end
    nvec++; if (rise[4] - rise[3] !== 21) begin nerr++; $display("FAIL resend_single: got %0d want 21", rise[4] - rise[3]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_bid0();
    test_midframe_change();
    test_rst_midframe();
    test_resend();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
